// File: rtl/risc_mgmt_test_exec.sv
// Execute/memory-sequencing unit for the RISC-MGMT test extension.
// Runs one decoded test instruction at a time through IDLE/STALL/MEM/RESP; every output is registered.
module risc_mgmt_test_exec #(
    parameter int IMM_W        = 9,
    parameter int STALL_CYCLES = 5,
    parameter int VAR_STALL_EN = 0,
    parameter int MEM_TIMEOUT  = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [3:0]       funct,
    input  logic [IMM_W-1:0] imm,
    input  logic [31:0]      rs_0_data,
    input  logic [31:0]      rs_1_data,
    input  logic [31:0]      pc,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             rd_wen,
    output logic [31:0]      rd_data,
    output logic             br_j_taken,
    output logic [31:0]      br_j_addr,
    output logic             exception,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_store,
    input  logic             mem_busy,
    input  logic [31:0]      mem_load
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [3:0] F_RTYPE       = 4'd0;
    localparam logic [3:0] F_RTYPE_STALL = 4'd1;
    localparam logic [3:0] F_BR_J        = 4'd2;
    localparam logic [3:0] F_MEM_LOAD    = 4'd3;
    localparam logic [3:0] F_MEM_STORE   = 4'd4;
    localparam logic [3:0] F_NOP         = 4'd6;

    localparam logic [7:0]  FIX_STALL = 8'(STALL_CYCLES);
    localparam bit          TMO_EN    = (MEM_TIMEOUT > 0);
    localparam logic [31:0] TMO_LAST  = TMO_EN ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] v);
        return {{(32-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    logic [1:0]  state_r, state_nx_s;
    logic [7:0]  stall_cnt_r, stall_cnt_nx_s;
    logic [31:0] tmo_cnt_r, tmo_cnt_nx_s;
    logic [31:0] sum_r, sum_nx_s;
    logic        busy_r, done_r, rd_wen_r, br_j_taken_r, exception_r, mem_ren_r, mem_wen_r;
    logic        done_nx_s, rd_wen_nx_s, br_j_taken_nx_s, exception_nx_s, mem_ren_nx_s, mem_wen_nx_s;
    logic [31:0] rd_data_r, br_j_addr_r, mem_addr_r, mem_store_r;
    logic [31:0] rd_data_nx_s, br_j_addr_nx_s, mem_addr_nx_s, mem_store_nx_s;
    logic [7:0]  stall_len_s;
    logic [31:0] imm_ext_s;

    // Stall length: fixed parameter or low nibble of the immediate.
    always_comb begin
        imm_ext_s = sext_imm(imm);
        if (VAR_STALL_EN != 0) begin
            stall_len_s = {4'd0, imm[3:0]};
        end else begin
            stall_len_s = FIX_STALL;
        end
    end

    // Next-state and next-output computation; pulses default low every cycle.
    always_comb begin
        state_nx_s      = state_r;
        stall_cnt_nx_s  = stall_cnt_r;
        tmo_cnt_nx_s    = tmo_cnt_r;
        sum_nx_s        = sum_r;
        done_nx_s       = 1'b0;
        rd_wen_nx_s     = 1'b0;
        br_j_taken_nx_s = 1'b0;
        exception_nx_s  = 1'b0;
        rd_data_nx_s    = rd_data_r;
        br_j_addr_nx_s  = br_j_addr_r;
        mem_ren_nx_s    = mem_ren_r;
        mem_wen_nx_s    = mem_wen_r;
        mem_addr_nx_s   = mem_addr_r;
        mem_store_nx_s  = mem_store_r;
        if (flush) begin
            state_nx_s   = ST_IDLE;
            mem_ren_nx_s = 1'b0;
            mem_wen_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (funct)
                            F_RTYPE, F_RTYPE_STALL: begin
                                if ((funct == F_RTYPE_STALL) && (stall_len_s != 8'd0)) begin
                                    state_nx_s     = ST_STALL;
                                    stall_cnt_nx_s = stall_len_s;
                                    sum_nx_s       = rs_0_data + rs_1_data;
                                end else begin
                                    state_nx_s   = ST_RESP;
                                    done_nx_s    = 1'b1;
                                    rd_wen_nx_s  = 1'b1;
                                    rd_data_nx_s = rs_0_data + rs_1_data;
                                end
                            end
                            F_BR_J: begin
                                state_nx_s      = ST_RESP;
                                done_nx_s       = 1'b1;
                                br_j_taken_nx_s = 1'b1;
                                br_j_addr_nx_s  = pc + {imm_ext_s[30:0], 1'b0};
                            end
                            F_MEM_LOAD, F_MEM_STORE: begin
                                state_nx_s     = ST_MEM;
                                mem_ren_nx_s   = (funct == F_MEM_LOAD);
                                mem_wen_nx_s   = (funct == F_MEM_STORE);
                                mem_addr_nx_s  = rs_0_data + imm_ext_s;
                                mem_store_nx_s = rs_1_data;
                                tmo_cnt_nx_s   = 32'd0;
                            end
                            F_NOP: begin
                                state_nx_s = ST_RESP;
                                done_nx_s  = 1'b1;
                            end
                            default: begin
                                state_nx_s     = ST_RESP;
                                done_nx_s      = 1'b1;
                                exception_nx_s = 1'b1;
                            end
                        endcase
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (stall_cnt_r == 8'd1) begin
                        state_nx_s   = ST_RESP;
                        done_nx_s    = 1'b1;
                        rd_wen_nx_s  = 1'b1;
                        rd_data_nx_s = sum_r;
                    end else begin
                        stall_cnt_nx_s = stall_cnt_r - 8'd1;
                    end
                end
                ST_MEM: begin
                    if (!mem_busy) begin
                        state_nx_s   = ST_RESP;
                        done_nx_s    = 1'b1;
                        mem_ren_nx_s = 1'b0;
                        mem_wen_nx_s = 1'b0;
                        if (mem_ren_r) begin
                            rd_wen_nx_s  = 1'b1;
                            rd_data_nx_s = mem_load;
                        end else begin
                            rd_wen_nx_s = 1'b0;
                        end
                    end else if (TMO_EN && (tmo_cnt_r == TMO_LAST)) begin
                        // Busy for MEM_TIMEOUT consecutive cycles: drop the request and trap.
                        state_nx_s     = ST_RESP;
                        done_nx_s      = 1'b1;
                        exception_nx_s = 1'b1;
                        mem_ren_nx_s   = 1'b0;
                        mem_wen_nx_s   = 1'b0;
                    end else begin
                        tmo_cnt_nx_s = tmo_cnt_r + 32'd1;
                    end
                end
                ST_RESP: begin
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s   = ST_IDLE;
                    mem_ren_nx_s = 1'b0;
                    mem_wen_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            stall_cnt_r  <= 8'd0;
            tmo_cnt_r    <= 32'd0;
            sum_r        <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rd_wen_r     <= 1'b0;
            rd_data_r    <= 32'd0;
            br_j_taken_r <= 1'b0;
            br_j_addr_r  <= 32'd0;
            exception_r  <= 1'b0;
            mem_ren_r    <= 1'b0;
            mem_wen_r    <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_store_r  <= 32'd0;
        end else begin
            state_r      <= state_nx_s;
            stall_cnt_r  <= stall_cnt_nx_s;
            tmo_cnt_r    <= tmo_cnt_nx_s;
            sum_r        <= sum_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            done_r       <= done_nx_s;
            rd_wen_r     <= rd_wen_nx_s;
            rd_data_r    <= rd_data_nx_s;
            br_j_taken_r <= br_j_taken_nx_s;
            br_j_addr_r  <= br_j_addr_nx_s;
            exception_r  <= exception_nx_s;
            mem_ren_r    <= mem_ren_nx_s;
            mem_wen_r    <= mem_wen_nx_s;
            mem_addr_r   <= mem_addr_nx_s;
            mem_store_r  <= mem_store_nx_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign rd_wen     = rd_wen_r;
    assign rd_data    = rd_data_r;
    assign br_j_taken = br_j_taken_r;
    assign br_j_addr  = br_j_addr_r;
    assign exception  = exception_r;
    assign mem_ren    = mem_ren_r;
    assign mem_wen    = mem_wen_r;
    assign mem_addr   = mem_addr_r;
    assign mem_store  = mem_store_r;

endmodule

// File: tb/tb_risc_mgmt_test_exec.sv
// Directed bench for risc_mgmt_test_exec: instance a uses defaults, instance b uses
// variable stall length and a 4-cycle memory timeout; both share the same stimulus.
module tb_risc_mgmt_test_exec;

    logic        CLK, RST, start, flush, mem_busy;
    logic [3:0]  funct;
    logic [8:0]  imm;
    logic [31:0] rs_0_data, rs_1_data, pc, mem_load;

    logic        a_busy, a_done, a_rd_wen, a_br, a_exc, a_ren, a_wen;
    logic [31:0] a_rd_data, a_br_addr, a_mem_addr, a_mem_store;
    logic        b_busy, b_done, b_rd_wen, b_br, b_exc, b_ren, b_wen;
    logic [31:0] b_rd_data, b_br_addr, b_mem_addr, b_mem_store;

    int total = 0;
    int bad   = 0;

    risc_mgmt_test_exec #(.IMM_W(9), .STALL_CYCLES(5), .VAR_STALL_EN(0), .MEM_TIMEOUT(0)) dut_a (
        .CLK(CLK), .RST(RST), .start(start), .funct(funct), .imm(imm),
        .rs_0_data(rs_0_data), .rs_1_data(rs_1_data), .pc(pc), .flush(flush),
        .busy(a_busy), .done(a_done), .rd_wen(a_rd_wen), .rd_data(a_rd_data),
        .br_j_taken(a_br), .br_j_addr(a_br_addr), .exception(a_exc),
        .mem_ren(a_ren), .mem_wen(a_wen), .mem_addr(a_mem_addr), .mem_store(a_mem_store),
        .mem_busy(mem_busy), .mem_load(mem_load)
    );

    risc_mgmt_test_exec #(.IMM_W(9), .STALL_CYCLES(5), .VAR_STALL_EN(1), .MEM_TIMEOUT(4)) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .funct(funct), .imm(imm),
        .rs_0_data(rs_0_data), .rs_1_data(rs_1_data), .pc(pc), .flush(flush),
        .busy(b_busy), .done(b_done), .rd_wen(b_rd_wen), .rd_data(b_rd_data),
        .br_j_taken(b_br), .br_j_addr(b_br_addr), .exception(b_exc),
        .mem_ren(b_ren), .mem_wen(b_wen), .mem_addr(b_mem_addr), .mem_store(b_mem_store),
        .mem_busy(mem_busy), .mem_load(mem_load)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  funct;
        logic [8:0]  imm;
        logic [31:0] rs0;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic        e_wen;
        logic [31:0] e_data;
        logic        e_br;
        logic [31:0] e_addr;
        logic        e_exc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input logic [8:0] im,
                         input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] p);
        start     = 1'b1;
        funct     = f;
        imm       = im;
        rs_0_data = r0;
        rs_1_data = r1;
        pc        = p;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        vecs[0] = '{4'd0, 9'h000, 32'hFFFF_FFFF, 32'd2,          32'h0,      1'b1, 32'h0000_0001, 1'b0, 32'h0,         1'b0};
        vecs[1] = '{4'd0, 9'h000, 32'h1234_5678, 32'h1111_1111,  32'h0,      1'b1, 32'h2345_6789, 1'b0, 32'h0,         1'b0};
        vecs[2] = '{4'd2, 9'h1FC, 32'h0,         32'h0,          32'h100,    1'b0, 32'h0,         1'b1, 32'h0000_00F8, 1'b0};
        vecs[3] = '{4'd2, 9'h0FF, 32'h0,         32'h0,          32'h1000,   1'b0, 32'h0,         1'b1, 32'h0000_11FE, 1'b0};
        vecs[4] = '{4'd2, 9'h100, 32'h0,         32'h0,          32'h0,      1'b0, 32'h0,         1'b1, 32'hFFFF_FE00, 1'b0};
        vecs[5] = '{4'd5, 9'h000, 32'h0,         32'h0,          32'h0,      1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[6] = '{4'd6, 9'h000, 32'h0,         32'h0,          32'h0,      1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[7] = '{4'd7, 9'h000, 32'h0,         32'h0,          32'h0,      1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[8] = '{4'd15, 9'h000, 32'h0,        32'h0,          32'h0,      1'b0, 32'h0,         1'b0, 32'h0,         1'b1};

        RST = 1'b1; start = 1'b0; flush = 1'b0; mem_busy = 1'b0; mem_load = 32'h0;
        funct = 4'd0; imm = 9'd0; rs_0_data = 32'd0; rs_1_data = 32'd0; pc = 32'd0;

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge CLK);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_pulses", {26'd0, a_done, a_rd_wen, a_br, a_exc, a_ren, a_wen}, 32'd0);
        chk("rst_rd_data", a_rd_data, 32'd0);
        chk("rst_br_addr", a_br_addr, 32'd0);
        chk("rst_mem_addr", a_mem_addr, 32'd0);
        chk("rst_b_pulses", {26'd0, b_done, b_rd_wen, b_br, b_exc, b_ren, b_wen}, 32'd0);
        next_cycle();
        RST = 1'b0;
        idle(2);

        // Single-cycle ops, issued back-to-back each cycle after the previous done
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].funct, vecs[v].imm, vecs[v].rs0, vecs[v].rs1, vecs[v].pc);
            next_cycle();
            start = 1'b0;
            @(negedge CLK);
            chk("vec_done", {31'd0, a_done}, 32'd1);
            chk("vec_busy", {31'd0, a_busy}, 32'd1);
            chk("vec_rd_wen", {31'd0, a_rd_wen}, {31'd0, vecs[v].e_wen});
            chk("vec_br", {31'd0, a_br}, {31'd0, vecs[v].e_br});
            chk("vec_exc", {31'd0, a_exc}, {31'd0, vecs[v].e_exc});
            if (vecs[v].e_wen) chk("vec_rd_data", a_rd_data, vecs[v].e_data);
            if (vecs[v].e_br) chk("vec_br_addr", a_br_addr, vecs[v].e_addr);
            next_cycle();
            @(negedge CLK);
            chk("vec_idle_done", {31'd0, a_done}, 32'd0);
            chk("vec_idle_busy", {31'd0, a_busy}, 32'd0);
        end
        idle(2);

        // Fixed stall of 5 on instance a
        issue(4'd1, 9'd0, 32'd3, 32'd4, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            start = 1'b0;
            @(negedge CLK);
            chk("stall5_busy", {31'd0, a_busy}, {31'd0, c <= 6});
            chk("stall5_done", {31'd0, a_done}, {31'd0, c == 6});
            if (c == 6) chk("stall5_rd_data", a_rd_data, 32'd7);
        end
        idle(2);

        // Variable stall, imm[3:0]=0 behaves as plain RTYPE
        issue(4'd1, 9'h0F0, 32'd10, 32'd20, 32'd0);
        next_cycle();
        start = 1'b0;
        @(negedge CLK);
        chk("var0_done", {31'd0, b_done}, 32'd1);
        chk("var0_rd", b_rd_data, 32'd30);
        idle(10);

        // Variable stall, imm[3:0]=15
        issue(4'd1, 9'h00F, 32'd1, 32'd1, 32'd0);
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            start = 1'b0;
            @(negedge CLK);
            chk("var15_done", {31'd0, b_done}, {31'd0, c == 16});
            chk("var15_busy", {31'd0, b_busy}, {31'd0, c <= 16});
        end
        idle(4);

        // Load with 3 busy cycles on instance a
        mem_load = 32'hDEAD_BEEF;
        issue(4'd3, 9'd8, 32'h2000, 32'h55, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            start = 1'b0;
            mem_busy = (c <= 3);
            @(negedge CLK);
            chk("ld_ren", {31'd0, a_ren}, {31'd0, c <= 4});
            chk("ld_wen", {31'd0, a_wen}, 32'd0);
            chk("ld_done", {31'd0, a_done}, {31'd0, c == 5});
            if (c <= 4) chk("ld_addr", a_mem_addr, 32'h2008);
            if (c == 5) chk("ld_rd_data", a_rd_data, 32'hDEAD_BEEF);
            if (c == 5) chk("ld_rd_wen", {31'd0, a_rd_wen}, 32'd1);
        end
        mem_busy = 1'b0;
        idle(3);

        // Store timing out on instance b
        issue(4'd4, 9'd0, 32'h3000, 32'hCAFE_F00D, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            start = 1'b0;
            mem_busy = 1'b1;
            @(negedge CLK);
            chk("tmo_wen", {31'd0, b_wen}, {31'd0, c <= 4});
            chk("tmo_done", {31'd0, b_done}, {31'd0, c == 5});
            chk("tmo_exc", {31'd0, b_exc}, {31'd0, c == 5});
            chk("tmo_rd_wen", {31'd0, b_rd_wen}, 32'd0);
            if (c == 1) chk("tmo_store", b_mem_store, 32'hCAFE_F00D);
        end
        mem_busy = 1'b0;
        idle(4);

        // Flush in stall cycle 3 on instance a
        issue(4'd1, 9'd0, 32'd1, 32'd2, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            start = 1'b0;
            flush = (c == 3);
            @(negedge CLK);
            chk("flush_busy", {31'd0, a_busy}, {31'd0, c <= 3});
            chk("flush_done", {31'd0, a_done}, 32'd0);
            chk("flush_mem", {30'd0, a_ren, a_wen}, 32'd0);
        end
        flush = 1'b0;
        idle(2);

        // Flush coinciding with the RESP cycle keeps that done
        issue(4'd0, 9'd0, 32'd5, 32'd6, 32'd0);
        next_cycle();
        start = 1'b0;
        flush = 1'b1;
        @(negedge CLK);
        chk("flush_resp_done", {31'd0, a_done}, 32'd1);
        chk("flush_resp_data", a_rd_data, 32'd11);
        next_cycle();
        flush = 1'b0;
        @(negedge CLK);
        chk("flush_resp_after", {31'd0, a_done}, 32'd0);
        idle(8);

        // Start while busy is dropped
        issue(4'd1, 9'd0, 32'd100, 32'd1, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (c == 2) issue(4'd0, 9'd0, 32'd7, 32'd7, 32'd0);
            else start = 1'b0;
            @(negedge CLK);
            chk("drop_done", {31'd0, a_done}, {31'd0, c == 6});
            chk("drop_busy", {31'd0, a_busy}, {31'd0, c <= 6});
            if (c == 6) chk("drop_rd_data", a_rd_data, 32'd101);
        end
        idle(8);

        // Asynchronous reset while in MEM
        issue(4'd3, 9'd4, 32'h4000, 32'd0, 32'h80);
        next_cycle();
        start = 1'b0;
        mem_busy = 1'b1;
        @(negedge CLK);
        chk("rstmem_ren_before", {31'd0, a_ren}, 32'd1);
        next_cycle();
        #1;
        RST = 1'b1;
        #1;
        chk("rstmem_ren", {31'd0, a_ren}, 32'd0);
        chk("rstmem_busy", {31'd0, a_busy}, 32'd0);
        chk("rstmem_addr", a_mem_addr, 32'd0);
        chk("rstmem_rd_data", a_rd_data, 32'd0);
        chk("rstmem_br_addr", a_br_addr, 32'd0);
        next_cycle();
        RST = 1'b0;
        mem_busy = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
